mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one mem_system between an instruction-fetch side and a data side.
// One access is in flight at a time; a watchdog ends an access that never completes.
module mem_arbiter #(
   parameter int TIMEOUT = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IRd,
   input  logic [15:0] IAddr,
   output logic [15:0] IDataOut,
   output logic        IDone,
   output logic        IStall,
   input  logic        DRd,
   input  logic        DWr,
   input  logic [15:0] DAddr,
   input  logic [15:0] DDataIn,
   output logic [15:0] DDataOut,
   output logic        DDone,
   output logic        DStall,
   output logic [15:0] MAddr,
   output logic [15:0] MDataIn,
   output logic        MRd,
   output logic        MWr,
   input  logic [15:0] MDataOut,
   input  logic        MDone,
   input  logic        MErr,
   output logic        err
);

   // state  | meaning
   // IDLE   | no access outstanding, arbitrate pending requests
   // SERV_I | instruction fetch outstanding on mem_system
   // SERV_D | data read/write outstanding on mem_system
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SERV_I = 2'd1;
   localparam logic [1:0] SERV_D = 2'd2;

   localparam logic [5:0] WD_LIMIT = 6'(TIMEOUT);

   logic [1:0]  state;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        wr_q;
   logic        last_d;
   logic [5:0]  wd_cnt;
   logic        err_q;
   logic [15:0] idata_q;
   logic [15:0] ddata_q;

   logic        d_req;
   logic        in_serv;
   logic        wd_expired;
   logic        done;
   logic        grant_d;
   logic [15:0] rsp_data;

   assign d_req      = DRd | DWr;
   assign in_serv    = (state == SERV_I) || (state == SERV_D);
   // A real completion takes precedence over an expiring watchdog in the same cycle.
   assign wd_expired = in_serv && !MDone && (wd_cnt == WD_LIMIT);
   assign done       = in_serv && (MDone || wd_expired);
   assign grant_d    = d_req && (!IRd || !last_d);
   assign rsp_data   = MDone ? MDataOut : 16'h0000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         wr_q    <= 1'b0;
         last_d  <= 1'b0;
         wd_cnt  <= 6'd0;
         err_q   <= 1'b0;
         idata_q <= 16'h0000;
         ddata_q <= 16'h0000;
      end else begin
         if (MErr || wd_expired)
            err_q <= 1'b1;
         case (state)
            IDLE: begin
               if (IRd || d_req) begin
                  state   <= grant_d ? SERV_D : SERV_I;
                  addr_q  <= grant_d ? DAddr : IAddr;
                  wdata_q <= grant_d ? DDataIn : 16'h0000;
                  wr_q    <= grant_d & DWr;
                  wd_cnt  <= 6'd0;
               end
            end
            SERV_I, SERV_D: begin
               if (done) begin
                  state  <= IDLE;
                  last_d <= (state == SERV_D);
                  if (state == SERV_I)
                     idata_q <= rsp_data;
                  else
                     ddata_q <= rsp_data;
               end else begin
                  wd_cnt <= wd_cnt + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign MRd     = in_serv & ~wr_q;
   assign MWr     = in_serv & wr_q;
   assign MAddr   = in_serv ? addr_q : 16'h0000;
   assign MDataIn = in_serv ? wdata_q : 16'h0000;

   assign IDone    = done && (state == SERV_I);
   assign DDone    = done && (state == SERV_D);
   assign IDataOut = IDone ? rsp_data : idata_q;
   assign DDataOut = DDone ? rsp_data : ddata_q;
   assign IStall   = IRd & ~IDone;
   assign DStall   = d_req & ~DDone;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus sequences for
// address hold, grant alternation, watchdog timeout and reset mid-access.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        IRd, DRd, DWr, MDone, MErr;
   logic [15:0] IAddr, DAddr, DDataIn, MDataOut;
   logic [15:0] IDataOut, DDataOut, MAddr, MDataIn;
   logic        IDone, IStall, DDone, DStall, MRd, MWr, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .IRd(IRd), .IAddr(IAddr), .IDataOut(IDataOut), .IDone(IDone), .IStall(IStall),
      .DRd(DRd), .DWr(DWr), .DAddr(DAddr), .DDataIn(DDataIn),
      .DDataOut(DDataOut), .DDone(DDone), .DStall(DStall),
      .MAddr(MAddr), .MDataIn(MDataIn), .MRd(MRd), .MWr(MWr),
      .MDataOut(MDataOut), .MDone(MDone), .MErr(MErr), .err(err)
   );

   typedef struct {
      logic        ird, drd, dwr, mdone, merr;
      logic [15:0] iaddr, daddr, ddin, mdout;
      logic        mrd, mwr;
      logic [15:0] maddr, mdin;
      logic        idone, ddone;
      logic [15:0] idout, ddout;
      logic        istall, dstall, err;
   } vec_t;

   vec_t vt[20];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      IRd = 0; DRd = 0; DWr = 0; MDone = 0; MErr = 0;
      IAddr = 0; DAddr = 0; DDataIn = 0; MDataOut = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      clear_inputs();
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [15:0] ord[4];
      // ird drd dwr mdone merr | iaddr daddr ddin mdout | mrd mwr maddr mdin | idone ddone idout ddout | istall dstall err
      vt[0]  = '{0,0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0};
      vt[1]  = '{1,0,0,0,0, 16'h0040,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0};
      vt[2]  = '{1,0,0,0,0, 16'h0040,16'h0000,16'h0000,16'h0000, 1,0,16'h0040,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0};
      vt[3]  = '{1,0,0,1,0, 16'h0040,16'h0000,16'h0000,16'h1234, 1,0,16'h0040,16'h0000, 1,0,16'h1234,16'h0000, 0,0,0};
      vt[4]  = '{0,0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h1234,16'h0000, 0,0,0};
      vt[5]  = '{1,0,1,0,0, 16'h0050,16'h0100,16'hBEEF,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h1234,16'h0000, 1,1,0};
      vt[6]  = '{1,0,1,0,0, 16'h0050,16'h0100,16'hBEEF,16'h0000, 0,1,16'h0100,16'hBEEF, 0,0,16'h1234,16'h0000, 1,1,0};
      vt[7]  = '{1,0,1,1,0, 16'h0050,16'h0100,16'hBEEF,16'h5555, 0,1,16'h0100,16'hBEEF, 0,1,16'h1234,16'h5555, 1,0,0};
      vt[8]  = '{1,0,0,0,0, 16'h0050,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h1234,16'h5555, 1,0,0};
      vt[9]  = '{1,0,0,0,0, 16'h0050,16'h0000,16'h0000,16'h0000, 1,0,16'h0050,16'h0000, 0,0,16'h1234,16'h5555, 1,0,0};
      vt[10] = '{1,0,0,1,0, 16'h0050,16'h0000,16'h0000,16'hABCD, 1,0,16'h0050,16'h0000, 1,0,16'hABCD,16'h5555, 0,0,0};
      vt[11] = '{0,0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'hABCD,16'h5555, 0,0,0};
      vt[12] = '{0,1,1,0,0, 16'h0000,16'h0300,16'h00FF,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'hABCD,16'h5555, 0,1,0};
      vt[13] = '{0,1,1,0,0, 16'h0000,16'h0300,16'h00FF,16'h0000, 0,1,16'h0300,16'h00FF, 0,0,16'hABCD,16'h5555, 0,1,0};
      vt[14] = '{0,1,1,1,0, 16'h0000,16'h0300,16'h00FF,16'h7777, 0,1,16'h0300,16'h00FF, 0,1,16'hABCD,16'h7777, 0,0,0};
      vt[15] = '{0,1,0,0,0, 16'h0000,16'h0400,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'hABCD,16'h7777, 0,1,0};
      vt[16] = '{0,1,0,0,0, 16'h0000,16'h0400,16'h0000,16'h0000, 1,0,16'h0400,16'h0000, 0,0,16'hABCD,16'h7777, 0,1,0};
      vt[17] = '{0,1,0,1,0, 16'h0000,16'h0400,16'h0000,16'h4242, 1,0,16'h0400,16'h0000, 0,1,16'hABCD,16'h4242, 0,0,0};
      vt[18] = '{0,0,0,1,1, 16'h0000,16'h0000,16'h0000,16'hFFFF, 0,0,16'h0000,16'h0000, 0,0,16'hABCD,16'h4242, 0,0,0};
      vt[19] = '{0,0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'hABCD,16'h4242, 0,0,1};

      // Reset state, with an instruction request already pending
      rst = 0;
      clear_inputs();
      IRd = 1;
      #2;
      chk1("rst mrd", MRd, 1'b0);
      chk1("rst mwr", MWr, 1'b0);
      chk("rst maddr", MAddr, 16'h0000);
      chk1("rst idone", IDone, 1'b0);
      chk("rst idout", IDataOut, 16'h0000);
      chk1("rst istall", IStall, 1'b1);
      chk1("rst dstall", DStall, 1'b0);
      chk1("rst err", err, 1'b0);
      @(negedge clk);
      IRd = 0;
      rst = 1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         IRd = vt[i].ird; DRd = vt[i].drd; DWr = vt[i].dwr;
         MDone = vt[i].mdone; MErr = vt[i].merr;
         IAddr = vt[i].iaddr; DAddr = vt[i].daddr; DDataIn = vt[i].ddin; MDataOut = vt[i].mdout;
         #1;
         chk1($sformatf("v%0d mrd", i), MRd, vt[i].mrd);
         chk1($sformatf("v%0d mwr", i), MWr, vt[i].mwr);
         chk($sformatf("v%0d maddr", i), MAddr, vt[i].maddr);
         chk($sformatf("v%0d mdatain", i), MDataIn, vt[i].mdin);
         chk1($sformatf("v%0d idone", i), IDone, vt[i].idone);
         chk1($sformatf("v%0d ddone", i), DDone, vt[i].ddone);
         chk($sformatf("v%0d idataout", i), IDataOut, vt[i].idout);
         chk($sformatf("v%0d ddataout", i), DDataOut, vt[i].ddout);
         chk1($sformatf("v%0d istall", i), IStall, vt[i].istall);
         chk1($sformatf("v%0d dstall", i), DStall, vt[i].dstall);
         chk1($sformatf("v%0d err", i), err, vt[i].err);
      end

      // Latched address must not follow DAddr during a long access
      do_reset();
      @(negedge clk);
      DWr = 1; DAddr = 16'h0100; DDataIn = 16'h1111;
      @(negedge clk);
      DAddr = 16'h0200;
      #1;
      chk1("hold mwr", MWr, 1'b1);
      chk("hold maddr0", MAddr, 16'h0100);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("hold maddr%0d", c), MAddr, 16'h0100);
         chk1($sformatf("hold ddone%0d", c), DDone, 1'b0);
      end
      MDone = 1;
      #1;
      chk1("hold ddone_end", DDone, 1'b1);
      chk("hold mdatain", MDataIn, 16'h1111);
      @(negedge clk);
      DWr = 0; MDone = 0;
      #1;
      chk1("hold idle mwr", MWr, 1'b0);

      // Continuous requests from both sides alternate, D first after reset
      do_reset();
      ord[0] = 16'h2000; ord[1] = 16'h1000; ord[2] = 16'h2000; ord[3] = 16'h1000;
      @(negedge clk);
      IRd = 1; IAddr = 16'h1000; DRd = 1; DAddr = 16'h2000;
      for (int g = 0; g < 4; g++) begin
         int n;
         logic found;
         n = 0;
         found = 0;
         while (!found && n < 10) begin
            @(negedge clk);
            #1;
            if (MRd) found = 1;
            n++;
         end
         chk1($sformatf("grant%0d seen", g), found, 1'b1);
         chk($sformatf("grant%0d addr", g), MAddr, ord[g]);
         MDone = 1;
         MDataOut = 16'h0A00 + 16'(g);
         #1;
         chk1($sformatf("grant%0d idone", g), IDone, ord[g] == 16'h1000);
         chk1($sformatf("grant%0d ddone", g), DDone, ord[g] == 16'h2000);
         chk1($sformatf("grant%0d istall", g), IStall, ord[g] == 16'h2000);
         @(negedge clk);
         MDone = 0;
      end
      IRd = 0; DRd = 0;

      // Watchdog: no MDone ever, Done pulses in SERV cycle 63 with zero data
      do_reset();
      @(negedge clk);
      IRd = 1; IAddr = 16'h0077; MDataOut = 16'h9999;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         #1;
         if (k == 0 || k >= 60) begin
            chk1($sformatf("wd%0d mrd", k), MRd, 1'b1);
            chk1($sformatf("wd%0d idone", k), IDone, k == 63);
         end
         if (k == 62) chk1("wd62 err", err, 1'b0);
         if (k == 63) begin
            chk("wd63 idataout", IDataOut, 16'h0000);
            IRd = 0;
         end
      end
      @(negedge clk);
      #1;
      chk1("wd after err", err, 1'b1);
      chk1("wd after mrd", MRd, 1'b0);
      chk1("wd after idone", IDone, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk1("wd sticky err", err, 1'b1);
      @(negedge clk);
      rst = 0;
      #1;
      chk1("wd cleared err", err, 1'b0);
      @(negedge clk);
      rst = 1;

      // Reset asserted in the third SERV_D cycle abandons the write
      do_reset();
      @(negedge clk);
      DWr = 1; DAddr = 16'h0100; DDataIn = 16'h2222;
      repeat (3) @(negedge clk);
      #1;
      chk1("rmid mwr before", MWr, 1'b1);
      rst = 0;
      #1;
      chk1("rmid mwr", MWr, 1'b0);
      chk("rmid maddr", MAddr, 16'h0000);
      chk("rmid mdatain", MDataIn, 16'h0000);
      chk1("rmid ddone", DDone, 1'b0);
      @(negedge clk);
      DWr = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      #1;
      chk1("rmid idle mwr", MWr, 1'b0);
      chk1("rmid idle mrd", MRd, 1'b0);
      chk("rmid idle ddataout", DDataOut, 16'h0000);
      IRd = 1; DWr = 1; IAddr = 16'h0011; DAddr = 16'h0022;
      @(negedge clk);
      #1;
      chk1("rmid regrant mwr", MWr, 1'b1);
      chk("rmid regrant maddr", MAddr, 16'h0022);
      IRd = 0; DWr = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
